// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate bounds and sticky flags.
// Define COUNTER_PRESCALER_EN to gate counting with a divide-by-PRESCALE strobe.
module updown_counter_mod #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] modulus,
  input  logic             saturate,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow,
  output logic             tick
);

  logic             step;
  logic             at_top;
  logic             at_zero;
  logic             up_bnd;
  logic             dn_bnd;
  logic [WIDTH-1:0] count_next;

`ifdef COUNTER_PRESCALER_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] psc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      psc <= '0;
    else if (load)
      psc <= '0;
    else if (enable)
      psc <= (psc == PS_MAX) ? '0 : psc + PS_W'(1);
  end

  assign tick = enable & (psc == PS_MAX);
`else
  assign tick = 1'b1;
`endif

  assign step    = enable & tick;
  assign at_top  = (count >= modulus);
  assign at_zero = (count == '0);
  assign up_bnd  = step & up_dn & at_top;
  assign dn_bnd  = step & ~up_dn & at_zero;
  assign tc      = up_bnd | dn_bnd;

  // A count left above a lowered modulus is pulled back to it on a down step without flagging.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = (load_value > modulus) ? modulus : load_value;
    end else if (step) begin
      if (up_dn)
        count_next = at_top ? (saturate ? modulus : '0) : count + WIDTH'(1);
      else if (at_zero)
        count_next = saturate ? '0 : modulus;
      else if (count > modulus)
        count_next = modulus;
      else
        count_next = count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      // Setting outranks clearing when both happen in one cycle.
      overflow  <= (up_bnd & ~load) | (overflow & ~clear_flags);
      underflow <= (dn_bnd & ~load) | (underflow & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: directed scenarios plus random stimulus
// checked against a behavioural model of the counting rules.
module tb_updown_counter_mod;
  localparam int W  = 4;
  localparam int PS = 3;

  logic         clk = 0;
  logic         reset = 1;
  logic         enable = 0, up_dn = 1, load = 0, saturate = 0, clear_flags = 0;
  logic [W-1:0] load_value = '0, modulus = 4'd9;
  logic [W-1:0] count;
  logic         tc, overflow, underflow, tick;

  updown_counter_mod #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_value(load_value), .modulus(modulus), .saturate(saturate),
    .clear_flags(clear_flags), .count(count), .tc(tc), .overflow(overflow),
    .underflow(underflow), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tc;
    bit tick;
    int cnt;
    bit ov;
    bit un;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int m_cnt = 0, m_psc = 0;
  bit m_ov = 0, m_un = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the model's expectation.
  task automatic cyc(input bit en, input bit ud, input bit ld, input int lv,
                     input int md, input bit sat, input bit clr);
    exp_t e;
    bit   tk, st;
    @(negedge clk);
    enable = en; up_dn = ud; load = ld; load_value = W'(lv);
    modulus = W'(md); saturate = sat; clear_flags = clr;
`ifdef COUNTER_PRESCALER_EN
    tk = en && (m_psc == PS - 1);
`else
    tk = 1;
`endif
    st = en && tk;
    e.tick = tk;
    e.tc   = st && ((ud && m_cnt >= md) || (!ud && m_cnt == 0));
    if (clr) begin m_ov = 0; m_un = 0; end
    if (ld) begin
      m_cnt = (lv < md) ? lv : md;
      m_psc = 0;
    end else begin
      if (st && ud) begin
        if (m_cnt < md) m_cnt = m_cnt + 1;
        else begin m_cnt = sat ? md : 0; m_ov = 1; end
      end else if (st) begin
        if (m_cnt == 0) begin m_cnt = sat ? 0 : md; m_un = 1; end
        else if (m_cnt > md) m_cnt = md;
        else m_cnt = m_cnt - 1;
      end
      if (en) m_psc = (m_psc + 1) % PS;
    end
    e.cnt = m_cnt; e.ov = m_ov; e.un = m_un;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1;
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_unf", int'(underflow), 0);
    m_cnt = 0; m_psc = 0; m_ov = 0; m_un = 0;
    enable = 0; load = 0; clear_flags = 0;
    @(negedge clk);
    reset = 0;
  endtask

  // Monitor: combinational outputs sampled mid-cycle, registered ones after the edge.
  initial begin
    bit   s_tc, s_tick;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      s_tc = tc; s_tick = tick;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tc", int'(s_tc), int'(e.tc));
        chk("tick", int'(s_tick), int'(e.tick));
        chk("count", int'(count), e.cnt);
        chk("overflow", int'(overflow), int'(e.ov));
        chk("underflow", int'(underflow), int'(e.un));
      end
    end
  end

  initial begin
    int md;
    #2;
    chk("init_count", int'(count), 0);
    chk("init_flags", int'({overflow, underflow}), 0);
    @(negedge clk);
    reset = 0;

    // count up to 5 (enough cycles for any prescale), then reset mid-count
    while (m_cnt != 5) cyc(1, 1, 0, 0, 9, 0, 0);
    do_reset();
    repeat (5) cyc(0, 1, 0, 0, 9, 0, 0);

    // up wrap through 9 -> 0, then clear
    repeat (12 * PS) cyc(1, 1, 0, 0, 9, 0, 0);
    cyc(0, 1, 0, 0, 9, 0, 1);

    // down saturate from 2, clear coinciding with underflow steps
    cyc(0, 0, 1, 2, 9, 1, 0);
    repeat (4 * PS) cyc(1, 0, 0, 0, 9, 1, 0);
    repeat (2 * PS) cyc(1, 0, 0, 0, 9, 1, 1);

    // load clamp with simultaneous enable, then lowered modulus
    cyc(0, 1, 0, 0, 9, 0, 1);
    cyc(1, 1, 1, 14, 9, 0, 0);
    repeat (PS) cyc(1, 0, 0, 0, 4, 0, 0);

    // prescaler spacing restarted by a mid-period load
    repeat (7) cyc(1, 1, 0, 0, 15, 0, 0);
    cyc(1, 1, 1, 3, 15, 0, 0);
    repeat (7) cyc(1, 1, 0, 0, 15, 0, 0);

    // modulus 0
    cyc(0, 1, 1, 7, 0, 0, 1);
    repeat (3 * PS) cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (3 * PS) cyc(1, 0, 0, 0, 0, 1, 0);

    // random traffic
    md = 9;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 15);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0, $urandom_range(0, 15), md,
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      if (i == 300) do_reset();
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
